fetch_buffer: RTL and testbench

Parametrised instruction fetch buffer sitting between the system-bus read path and the decoder. It accepts BUS_DATA_WIDTH-wide bus beats and splits each into INSN_WIDTH-wide instructions, lowest slot first. It queues the instructions in a DEPTH-entry FIFO, tags each with its PC, and hands them to the decoder over a valid/ready handshake. It supports pipeline flush with a redirect PC, including a redirect that is not aligned to a beat boundary.

---
 rtl/fetch_buffer.sv | 149 ++++++++++++++
 tb/tb_fetch_buffer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_buffer.sv
// fetch_buffer: splits bus beats into instructions, queues them with their PCs
// in a DEPTH-entry FIFO and presents the head to the decoder via valid/ready.
// Flush clears the queue and redirects fetch; a misaligned redirect skips the
// leading slots of the next beat.
// Optional macro FETCH_PERF_CNT_EN adds perf_beats / perf_insns counters.
module fetch_buffer #(
  parameter int unsigned BUS_DATA_WIDTH = 64,
  parameter int unsigned INSN_WIDTH     = 32,
  parameter int unsigned DEPTH          = 8,
  parameter int unsigned ADDR_WIDTH     = 64,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          bus_valid,
  output logic                          bus_ready,
  input  logic [BUS_DATA_WIDTH-1:0]     bus_data,
  input  logic                          flush,
  input  logic [ADDR_WIDTH-1:0]         redirect_pc,
  output logic                          ins_valid,
  input  logic                          ins_ready,
  output logic [INSN_WIDTH-1:0]         ins,
  output logic [ADDR_WIDTH-1:0]         ins_pc,
  output logic [$clog2(DEPTH+1)-1:0]    count
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]                   perf_beats,
  output logic [31:0]                   perf_insns
`endif
);

  localparam int unsigned SLOTS      = BUS_DATA_WIDTH / INSN_WIDTH;
  localparam int unsigned IB         = INSN_WIDTH / 8;
  localparam int unsigned BEAT_BYTES = SLOTS * IB;
  localparam int unsigned PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W      = $clog2(DEPTH + 1);
  localparam int unsigned SKIP_W     = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  logic [ADDR_WIDTH-1:0] next_pc_q, next_pc_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      occ_q, occ_d;

  logic [INSN_WIDTH-1:0] mem_insn_q [DEPTH];
  logic [ADDR_WIDTH-1:0] mem_pc_q   [DEPTH];

  logic [ADDR_WIDTH-1:0] beat_off;
  logic [SKIP_W-1:0]     skip;
  logic [CNT_W-1:0]      n_wr;
  logic [CNT_W-1:0]      free_slots;
  logic                  accept;
  logic                  deq;

  logic                  slot_we  [SLOTS];
  logic [PTR_W-1:0]      slot_idx [SLOTS];
  logic [ADDR_WIDTH-1:0] slot_pc  [SLOTS];

  // Handshake decode: readiness uses start-of-cycle occupancy only.
  always_comb begin
    beat_off   = next_pc_q % ADDR_WIDTH'(BEAT_BYTES);
    skip       = SKIP_W'(beat_off / ADDR_WIDTH'(IB));
    n_wr       = CNT_W'(SLOTS) - CNT_W'(skip);
    free_slots = CNT_W'(DEPTH) - occ_q;
    bus_ready  = !flush && (free_slots >= CNT_W'(SLOTS));
    accept     = bus_valid && bus_ready;
    ins_valid  = (occ_q != '0);
    deq        = ins_valid && ins_ready && !flush;
    count      = occ_q;
    ins        = ins_valid ? mem_insn_q[rd_ptr_q] : '0;
    ins_pc     = ins_valid ? mem_pc_q[rd_ptr_q]   : '0;
  end

  // Per-slot write enable, FIFO index and PC tag; slots below skip are dropped.
  always_comb begin
    for (int unsigned k = 0; k < SLOTS; k++) begin
      slot_we[k]  = accept && (k >= 32'(skip));
      slot_idx[k] = wr_ptr_q + PTR_W'(k) - PTR_W'(skip);
      slot_pc[k]  = next_pc_q
                  + (ADDR_WIDTH'(k) - ADDR_WIDTH'(skip)) * ADDR_WIDTH'(IB);
    end
  end

  // Next-state for pointers, occupancy and fetch PC; flush overrides everything.
  always_comb begin
    next_pc_d = next_pc_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    occ_d     = occ_q;
    if (flush) begin
      next_pc_d = redirect_pc;
      rd_ptr_d  = '0;
      wr_ptr_d  = '0;
      occ_d     = '0;
    end else begin
      if (accept) begin
        wr_ptr_d  = wr_ptr_q + PTR_W'(n_wr);
        next_pc_d = next_pc_q - beat_off + ADDR_WIDTH'(BEAT_BYTES);
      end
      if (deq) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      occ_d = occ_q + (accept ? n_wr : '0) - (deq ? CNT_W'(1) : '0);
    end
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      next_pc_q <= RESET_PC;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      occ_q     <= '0;
    end else begin
      next_pc_q <= next_pc_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      occ_q     <= occ_d;
    end
  end

  // Entry storage; contents are don't-care after reset so it is not reset.
  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < SLOTS; k++) begin
      if (slot_we[k]) begin
        mem_insn_q[slot_idx[k]] <= bus_data[k*INSN_WIDTH +: INSN_WIDTH];
        mem_pc_q[slot_idx[k]]   <= slot_pc[k];
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_beats_q, perf_insns_q;

  // Event counters: survive flush, cleared only by reset, wrap naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_beats_q <= '0;
      perf_insns_q <= '0;
    end else begin
      if (accept) perf_beats_q <= perf_beats_q + 32'd1;
      if (deq)    perf_insns_q <= perf_insns_q + 32'd1;
    end
  end

  assign perf_beats = perf_beats_q;
  assign perf_insns = perf_insns_q;
`endif

endmodule

// File: tb/tb_fetch_buffer.sv
// Scoreboard bench for fetch_buffer: a queue-based model predicts the FIFO
// contents; a negedge monitor compares the DUT head, count and bus_ready.
module tb_fetch_buffer;

  localparam logic [63:0] RST_PC = 64'h1000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        bus_valid;
  logic        bus_ready;
  logic [63:0] bus_data;
  logic        flush;
  logic [63:0] redirect_pc;
  logic        ins_valid;
  logic        ins_ready;
  logic [31:0] ins;
  logic [63:0] ins_pc;
  logic [3:0]  count;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_beats, perf_insns;
  int unsigned m_beats = 0, m_insns = 0;
`endif

  fetch_buffer #(
    .BUS_DATA_WIDTH(64),
    .INSN_WIDTH(32),
    .DEPTH(8),
    .ADDR_WIDTH(64),
    .RESET_PC(RST_PC)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus_valid(bus_valid),
    .bus_ready(bus_ready),
    .bus_data(bus_data),
    .flush(flush),
    .redirect_pc(redirect_pc),
    .ins_valid(ins_valid),
    .ins_ready(ins_ready),
    .ins(ins),
    .ins_pc(ins_pc),
    .count(count)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_beats(perf_beats),
    .perf_insns(perf_insns)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] insn;
    logic [63:0] pc;
  } ent_t;

  ent_t        exp_q[$];
  logic [63:0] m_npc = RST_PC;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: whole-instruction queue updated at each edge.
  initial forever begin
    bit   do_pop, do_acc;
    int   skip;
    ent_t e;
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      exp_q.delete();
      m_npc = RST_PC;
`ifdef FETCH_PERF_CNT_EN
      m_beats = 0; m_insns = 0;
`endif
    end else if (flush) begin
      exp_q.delete();
      m_npc = redirect_pc;
    end else begin
      do_pop = (exp_q.size() != 0) && ins_ready;
      do_acc = bus_valid && (8 - exp_q.size() >= 2);
      if (do_pop) void'(exp_q.pop_front());
      if (do_acc) begin
        skip = int'((m_npc % 64'd8) / 64'd4);
        for (int k = skip; k < 2; k++) begin
          e.insn = bus_data[k*32 +: 32];
          e.pc   = m_npc + 64'((k - skip) * 4);
          exp_q.push_back(e);
        end
        m_npc = m_npc - (m_npc % 64'd8) + 64'd8;
      end
`ifdef FETCH_PERF_CNT_EN
      if (do_pop) m_insns++;
      if (do_acc) m_beats++;
`endif
    end
  end

  // Monitor: compare visible DUT state against the model mid-cycle.
  initial forever begin
    logic exp_ready;
    @(negedge clk);
    exp_ready = !flush && (8 - exp_q.size() >= 2);
    chk("bus_ready", 64'(bus_ready), 64'(exp_ready));
    chk("count", 64'(count), 64'(exp_q.size()));
    chk("ins_valid", 64'(ins_valid), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      chk("ins", 64'(ins), 64'(exp_q[0].insn));
      chk("ins_pc", ins_pc, exp_q[0].pc);
    end else begin
      chk("ins_idle", 64'(ins), 64'd0);
      chk("ins_pc_idle", ins_pc, 64'd0);
    end
`ifdef FETCH_PERF_CNT_EN
    chk("perf_beats", 64'(perf_beats), 64'(m_beats));
    chk("perf_insns", 64'(perf_insns), 64'(m_insns));
`endif
  end

  // Inputs change 1ns after the rising edge and hold for the whole cycle.
  task automatic drive(input logic bv, input logic [63:0] bd, input logic ir,
                       input logic fl, input logic [63:0] rp);
    @(posedge clk);
    #1;
    bus_valid   = bv;
    bus_data    = bd;
    ins_ready   = ir;
    flush       = fl;
    redirect_pc = rp;
  endtask

  task automatic idle(input logic ir, input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 64'd0, ir, 1'b0, 64'd0);
  endtask

  initial begin
    logic [63:0] rp;
    reset_n = 1'b0; bus_valid = 1'b0; bus_data = '0; ins_ready = 1'b0;
    flush = 1'b0; redirect_pc = '0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // First beat after reset, consumed immediately.
    drive(1'b1, 64'hBBBBBBBB_AAAAAAAA, 1'b1, 1'b0, 64'd0);
    idle(1'b1, 4);

    // Misaligned redirect, then an aligned follow-up beat.
    drive(1'b0, 64'd0, 1'b0, 1'b1, 64'h2004);
    drive(1'b1, 64'h22222222_11111111, 1'b0, 1'b0, 64'd0);
    drive(1'b1, 64'h44444444_33333333, 1'b0, 1'b0, 64'd0);
    idle(1'b0, 1);
    idle(1'b1, 4);

    // Fill to DEPTH, drain two while the bus keeps pushing, then refill.
    drive(1'b0, 64'd0, 1'b0, 1'b1, 64'h8000);
    for (int i = 0; i < 6; i++)
      drive(1'b1, {32'h5000 + 32'(i), 32'h6000 + 32'(i)}, 1'b0, 1'b0, 64'd0);
    drive(1'b1, 64'h0BAD_0001_0BAD_0002, 1'b1, 1'b0, 64'd0);
    drive(1'b1, 64'h0BAD_0003_0BAD_0004, 1'b1, 1'b0, 64'd0);
    drive(1'b1, 64'h7777_7777_6666_6666, 1'b0, 1'b0, 64'd0);
    idle(1'b0, 1);
    idle(1'b1, 10);

    // Flush colliding with a beat and a dequeue at occupancy 4.
    drive(1'b1, 64'h1111_0000_2222_0000, 1'b0, 1'b0, 64'd0);
    drive(1'b1, 64'h3333_0000_4444_0000, 1'b0, 1'b0, 64'd0);
    drive(1'b1, 64'h5555_0000_6666_0000, 1'b1, 1'b1, 64'h5000);
    idle(1'b1, 2);

    // Asynchronous reset with five entries queued.
    drive(1'b0, 64'd0, 1'b0, 1'b1, 64'h3004);
    drive(1'b1, 64'hA1A1_A1A1_A0A0_A0A0, 1'b0, 1'b0, 64'd0);
    drive(1'b1, 64'hA3A3_A3A3_A2A2_A2A2, 1'b0, 1'b0, 64'd0);
    drive(1'b1, 64'hA5A5_A5A5_A4A4_A4A4, 1'b0, 1'b0, 64'd0);
    drive(1'b0, 64'd0, 1'b0, 1'b0, 64'd0);
    @(posedge clk);
    #3 chk("pre_rst_count", 64'(count), 64'd5);
    reset_n = 1'b0;
    #1;
    chk("rst_ins_valid", 64'(ins_valid), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_ins", 64'(ins), 64'd0);
    chk("rst_bus_ready", 64'(bus_ready), 64'd1);
`ifdef FETCH_PERF_CNT_EN
    chk("rst_perf_beats", 64'(perf_beats), 64'd0);
    chk("rst_perf_insns", 64'(perf_insns), 64'd0);
`endif
    @(posedge clk);
    #1 reset_n = 1'b1;
    drive(1'b1, 64'hCAFE_0002_CAFE_0001, 1'b1, 1'b0, 64'd0);
    idle(1'b1, 3);

    // Randomised traffic, including redirects near the top of the address space.
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 2))
        0:       rp = {$urandom, $urandom} & ~64'd3;
        1:       rp = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 3) * 4);
        default: rp = 64'h0001_0000 + 64'($urandom_range(0, 63) * 4);
      endcase
      drive($urandom_range(0, 3) != 0, {$urandom, $urandom},
            $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0, rp);
    end
    idle(1'b1, 12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
